// File: rtl/feed_ingress_pkt_fifo.sv
// feed_ingress_pkt_fifo: store-and-forward packet buffer in front of the feed decoder
// Ports:
//   clk, reset            core clock, asynchronous active-high reset
//   in_*                  Avalon-ST sink from MAC/UDP strip; in_ready is 1 after reset, never backpressures
//   out_*                 Avalon-ST source to decoder; only complete error-free packets, out_error tied 0
//   pkt_fwd_cnt           saturating count of committed packets
//   pkt_drop_cnt          saturating count of discarded packets
//   fill_level            beats held in RAM (committed + in-progress), excluding beats already read out
module feed_ingress_pkt_fifo #(
  parameter int DATA_WIDTH  = 64,
  parameter int EMPTY_WIDTH = 3,
  parameter int DEPTH_LOG2  = 9,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   in_ready,
  input  logic                   in_valid,
  input  logic                   in_startofpacket,
  input  logic                   in_endofpacket,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [EMPTY_WIDTH-1:0] in_empty,
  input  logic                   in_error,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic                   out_startofpacket,
  output logic                   out_endofpacket,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [EMPTY_WIDTH-1:0] out_empty,
  output logic                   out_error,
  output logic [CNT_WIDTH-1:0]   pkt_fwd_cnt,
  output logic [CNT_WIDTH-1:0]   pkt_drop_cnt,
  output logic [DEPTH_LOG2:0]    fill_level
);
  localparam int EW = 2 + EMPTY_WIDTH + DATA_WIDTH;
  localparam logic [1:0] IDLE = 2'd0, PKT = 2'd1, DROP = 2'd2;
  localparam logic [DEPTH_LOG2:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  logic [EW-1:0] mem [2**DEPTH_LOG2];
  logic [EW-1:0] ram_q;
  logic [DEPTH_LOG2:0] wr_ptr, commit_ptr, rd_ptr, wp_n, cp_n;
  logic [DEPTH_LOG2-1:0] wa;
  logic [1:0] st, st_n, drop_inc;
  logic [CNT_WIDTH:0] drop_sum;
  logic err_seen, err_n, we, fwd, drop_old, drop_new;
  logic full, sop_full, avail, q_valid, load_out, issue;
  assign out_error = 1'b0;
  assign fill_level = wr_ptr - rd_ptr;
  // full is judged against issued reads, so beats sitting in the prefetch stages count as freed
  assign full = (wr_ptr - rd_ptr) == DEPTH;
  // a new sop always lands at commit_ptr, since any open fragment is rewound first
  assign sop_full = (commit_ptr - rd_ptr) == DEPTH;
  assign avail = rd_ptr != commit_ptr;
  // two-stage read pipe: ram_q (RAM latency) then the output register
  assign load_out = q_valid & (~out_valid | out_ready);
  assign issue = avail & (~q_valid | load_out);
  assign drop_inc = {1'b0, drop_old} + {1'b0, drop_new};
  assign drop_sum = {1'b0, pkt_drop_cnt} + {{(CNT_WIDTH-1){1'b0}}, drop_inc};
  always_comb begin
    st_n = st;
    wp_n = wr_ptr;
    cp_n = commit_ptr;
    err_n = err_seen;
    we = 1'b0;
    wa = wr_ptr[DEPTH_LOG2-1:0];
    fwd = 1'b0;
    drop_old = 1'b0;
    drop_new = 1'b0;
    if (in_valid) begin
      if (in_startofpacket) begin
        // a sop outside IDLE closes out an unfinished (PKT) or already-doomed (DROP) packet
        drop_old = st != IDLE;
        wp_n = commit_ptr;
        st_n = IDLE;
        if (sop_full) begin
          drop_new = in_endofpacket;
          st_n = in_endofpacket ? IDLE : DROP;
        end else begin
          we = 1'b1;
          wa = commit_ptr[DEPTH_LOG2-1:0];
          err_n = in_error;
          if (!in_endofpacket) begin
            wp_n = commit_ptr + ONE;
            st_n = PKT;
          end else if (in_error) begin
            drop_new = 1'b1;
          end else begin
            wp_n = commit_ptr + ONE;
            cp_n = commit_ptr + ONE;
            fwd = 1'b1;
          end
        end
      end else if (st == PKT && full) begin
        // no room: abandon the packet; an eop here ends it, otherwise swallow the rest in DROP
        wp_n = commit_ptr;
        drop_new = in_endofpacket;
        st_n = in_endofpacket ? IDLE : DROP;
      end else if (st == PKT) begin
        we = 1'b1;
        err_n = err_seen | in_error;
        wp_n = wr_ptr + ONE;
        if (in_endofpacket) begin
          st_n = IDLE;
          if (err_seen | in_error) begin
            wp_n = commit_ptr;
            drop_new = 1'b1;
          end else begin
            cp_n = wr_ptr + ONE;
            fwd = 1'b1;
          end
        end
      end else if (st == DROP && in_endofpacket) begin
        drop_new = 1'b1;
        st_n = IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= {in_startofpacket, in_endofpacket, in_empty, in_data};
    if (issue) ram_q <= mem[rd_ptr[DEPTH_LOG2-1:0]];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready <= 1'b0;
      st <= IDLE;
      err_seen <= 1'b0;
      wr_ptr <= '0;
      commit_ptr <= '0;
      rd_ptr <= '0;
      q_valid <= 1'b0;
      out_valid <= 1'b0;
      out_startofpacket <= 1'b0;
      out_endofpacket <= 1'b0;
      out_empty <= '0;
      out_data <= '0;
      pkt_fwd_cnt <= '0;
      pkt_drop_cnt <= '0;
    end else begin
      in_ready <= 1'b1;
      st <= st_n;
      err_seen <= err_n;
      wr_ptr <= wp_n;
      commit_ptr <= cp_n;
      if (issue) rd_ptr <= rd_ptr + ONE;
      q_valid <= issue | (q_valid & ~load_out);
      out_valid <= load_out | (out_valid & ~out_ready);
      if (load_out) begin
        out_startofpacket <= ram_q[EW-1];
        out_endofpacket <= ram_q[EW-2];
        out_empty <= ram_q[DATA_WIDTH +: EMPTY_WIDTH];
        out_data <= ram_q[DATA_WIDTH-1:0];
      end
      if (fwd && !(&pkt_fwd_cnt)) pkt_fwd_cnt <= pkt_fwd_cnt + CNT_ONE;
      pkt_drop_cnt <= drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
    end
  end
endmodule

// File: tb/tb_feed_ingress_pkt_fifo.sv
// tb_feed_ingress_pkt_fifo: randomized scoreboard bench for the ingress packet buffer
module tb_feed_ingress_pkt_fifo;
  localparam int DW = 64, EW = 3, DL = 9, CW = 32, DEPTH = 1 << DL;
  typedef struct packed {
    logic sop;
    logic eop;
    logic [EW-1:0] empty;
    logic [DW-1:0] data;
  } beat_t;
  logic clk = 1'b0, reset = 1'b1;
  logic in_ready, in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0, in_err = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [EW-1:0] in_empty = '0;
  logic out_ready = 1'b0, out_valid, out_sop, out_eop, out_error;
  logic [DW-1:0] out_data;
  logic [EW-1:0] out_empty;
  logic [CW-1:0] fwd_cnt, drop_cnt;
  logic [DL:0] fill_level;
  beat_t sb[$], cur[$];
  beat_t held, mon_e;
  bit open_pkt = 1'b0, cur_err = 1'b0, hold_pend = 1'b0;
  int m_fwd = 0, m_drop = 0, vectors = 0, errors = 0, rmode = 0;
  always #5 clk = ~clk;
  feed_ingress_pkt_fifo #(.DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .DEPTH_LOG2(DL), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .in_ready(in_ready), .in_valid(in_valid),
    .in_startofpacket(in_sop), .in_endofpacket(in_eop), .in_data(in_data),
    .in_empty(in_empty), .in_error(in_err), .out_ready(out_ready), .out_valid(out_valid),
    .out_startofpacket(out_sop), .out_endofpacket(out_eop), .out_data(out_data),
    .out_empty(out_empty), .out_error(out_error), .pkt_fwd_cnt(fwd_cnt),
    .pkt_drop_cnt(drop_cnt), .fill_level(fill_level)
  );
  // monitor: every accepted output beat is popped from the scoreboard; stalled beats must hold
  always @(negedge clk) begin
    if (reset) hold_pend = 1'b0;
    else begin
      if (hold_pend) begin
        vectors++;
        if (!out_valid || {out_sop, out_eop, out_empty, out_data} !== held) begin
          errors++;
          $display("FAIL hold: got valid=%0b beat=%h, required valid=1 beat=%h", out_valid, {out_sop, out_eop, out_empty, out_data}, held);
        end
      end
      hold_pend = out_valid && !out_ready;
      held = {out_sop, out_eop, out_empty, out_data};
      if (out_valid && out_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL extra_beat: got sop=%0b eop=%0b data=%h, required no beat", out_sop, out_eop, out_data);
        end else begin
          mon_e = sb.pop_front();
          if (out_sop !== mon_e.sop || out_eop !== mon_e.eop || out_data !== mon_e.data || out_error !== 1'b0 || (mon_e.eop && out_empty !== mon_e.empty)) begin
            errors++;
            $display("FAIL beat: got sop=%0b eop=%0b err=%0b empty=%0d data=%h, required sop=%0b eop=%0b err=0 empty=%0d data=%h",
                     out_sop, out_eop, out_error, out_empty, out_data, mon_e.sop, mon_e.eop, mon_e.empty, mon_e.data);
          end
        end
      end
    end
  end
  // packet-level reference: a packet is delivered iff it opens with sop, closes with eop,
  // carries no errored beat and fits the buffer; stimulus drains the buffer before any long packet
  task automatic model(bit sop, bit eop, bit err, logic [DW-1:0] d, logic [EW-1:0] em);
    beat_t b;
    b = '{sop: sop, eop: eop, empty: em, data: d};
    if (sop) begin
      if (open_pkt) m_drop++;
      cur.delete();
      open_pkt = 1'b1;
      cur_err = 1'b0;
    end
    if (open_pkt) begin
      cur.push_back(b);
      cur_err |= err;
      if (eop) begin
        open_pkt = 1'b0;
        if (!cur_err && cur.size() <= DEPTH) begin
          foreach (cur[i]) sb.push_back(cur[i]);
          m_fwd++;
        end else m_drop++;
      end
    end
  endtask
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask
  task automatic chk_counts(string tag);
    chk({tag, "_fwd"}, 64'(fwd_cnt), 64'(m_fwd));
    chk({tag, "_drop"}, 64'(drop_cnt), 64'(m_drop));
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    if (rmode == 1) out_ready = $urandom_range(0, 9) < 7;
    else if (rmode == 2) out_ready = ~out_ready;
  endtask
  task automatic send(bit sop, bit eop, bit err, logic [DW-1:0] d, logic [EW-1:0] em);
    in_valid = 1'b1; in_sop = sop; in_eop = eop; in_err = err; in_data = d; in_empty = em;
    model(sop, eop, err, d, em);
    tick();
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_err = 1'b0;
  endtask
  task automatic send_pkt(int len, int err_beat, bit with_eop = 1'b1);
    for (int i = 0; i < len; i++)
      send(i == 0, with_eop && i == len - 1, i == err_beat, {$urandom, $urandom}, EW'($urandom));
  endtask
  task automatic drain(string tag);
    int n = 0;
    rmode = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 3000) begin
      tick();
      n++;
    end
    repeat (4) tick();
    chk({tag, "_drained"}, 64'(sb.size()), 64'd0);
    chk({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_fill"}, 64'(fill_level), 64'(cur.size() * int'(open_pkt)));
    chk_counts(tag);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end
  initial begin
    repeat (3) tick();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_fill", 64'(fill_level), 64'd0);
    chk_counts("rst");
    reset = 1'b0;
    repeat (2) tick();
    chk("in_ready", 64'(in_ready), 64'd1);
    // three-beat packet, latency from the eop edge
    out_ready = 1'b1;
    send(1, 0, 0, 64'h1111111111111111, 3'd0);
    send(0, 0, 0, 64'h2222222222222222, 3'd0);
    send(0, 1, 0, 64'h3333333333333333, 3'd2);
    @(negedge clk); chk("lat_e0", 64'(out_valid), 64'd0);
    @(negedge clk); chk("lat_e1", 64'(out_valid), 64'd0);
    @(negedge clk); chk("lat_e2", 64'(out_valid), 64'd1);
    chk("lat_data", out_data, 64'h1111111111111111);
    tick();
    drain("t1");
    // errored beat mid-packet, then a good one
    send_pkt(4, 1);
    send_pkt(2, -1);
    drain("t2");
    // overflow with the reader stalled, then a short packet
    out_ready = 1'b0;
    send_pkt(600, -1);
    repeat (5) tick();
    chk("ovf_valid", 64'(out_valid), 64'd0);
    chk_counts("ovf");
    send_pkt(4, -1);
    repeat (5) tick();
    drain("t3");
    // exact-capacity packet fits, one more beat does not
    out_ready = 1'b0;
    send_pkt(DEPTH, -1);
    repeat (3) tick();
    chk_counts("cap");
    drain("t3b");
    out_ready = 1'b0;
    send_pkt(DEPTH + 1, -1);
    repeat (5) tick();
    chk("cap1_valid", 64'(out_valid), 64'd0);
    drain("t3c");
    // stray beats in IDLE, then a fragment missing its eop
    send(0, 0, 0, {$urandom, $urandom}, 3'd0);
    send(0, 1, 1, {$urandom, $urandom}, 3'd5);
    send_pkt(2, -1, 1'b0);
    send_pkt(2, -1);
    drain("t4");
    // back-to-back packets under a toggling reader
    out_ready = 1'b0;
    rmode = 2;
    send_pkt(5, -1);
    send_pkt(5, -1);
    repeat (30) tick();
    drain("t5");
    // random traffic
    rmode = 1;
    for (int p = 0; p < 80; p++) begin
      int len, kind;
      repeat ($urandom_range(0, 4)) tick();
      len = $urandom_range(1, 16);
      kind = $urandom_range(0, 19);
      if (kind == 0) send(0, 1'($urandom), 1'($urandom), {$urandom, $urandom}, EW'($urandom));
      else if (kind == 1) send_pkt(len, -1, 1'b0);
      else send_pkt(len, ($urandom_range(0, 9) == 0) ? $urandom_range(0, len - 1) : -1);
    end
    send_pkt(2, -1);
    drain("rand");
    // reset in the middle of a packet
    send(1, 0, 0, {$urandom, $urandom}, 3'd0);
    send(0, 0, 0, {$urandom, $urandom}, 3'd0);
    chk("mid_fill", 64'(fill_level), 64'd2);
    in_valid = 1'b1; in_data = {$urandom, $urandom};
    #2 reset = 1'b1;
    #1;
    chk("mr_valid", 64'(out_valid), 64'd0);
    chk("mr_in_ready", 64'(in_ready), 64'd0);
    chk("mr_fill", 64'(fill_level), 64'd0);
    cur.delete(); open_pkt = 1'b0; m_fwd = 0; m_drop = 0; sb.delete();
    chk_counts("mr");
    in_valid = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (2) tick();
    send_pkt(5, -1);
    drain("t6");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
